// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants, exception causes and memory-stage state type
package riscv_pkg;

  localparam int ILEN           = 32;
  localparam int EXCEPTION_SIZE = 16;

  localparam logic [6:0]      OPC_LOAD  = 7'b000_0011;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam int CAUSE_MISALIGNED_LOAD = 4;
  localparam int CAUSE_LOAD_PAGE_FAULT = 13;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} mem_state_t;

endpackage

// File: rtl/riscv_mem_ldfmt.sv
// rtl/riscv_mem_ldfmt.sv - load data aligner and sign/zero extender
module riscv_mem_ldfmt
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      adr,
  input  logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = q[7:0];
    case (adr)
      2'd0: ld_byte = q[7:0];
      2'd1: ld_byte = q[15:8];
      2'd2: ld_byte = q[23:16];
      2'd3: ld_byte = q[31:24];
      default: ld_byte = q[7:0];
    endcase
    ld_half = adr[1] ? q[31:16] : q[15:0];

    r = q;
    case (funct3)
      F3_LB:   r = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  r = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   r = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  r = {{(XLEN-16){1'b0}}, ld_half};
      F3_LW:   r = q;
      default: r = q;
    endcase
  end

endmodule

// File: rtl/riscv_mem.sv
// rtl/riscv_mem.sv - memory-access pipeline stage with load wait/hold/drain tracking
// Optional RISCV_MEM_ACCESS_FAULT_EN: load faults set exception causes and zero the result.
module riscv_mem
  import riscv_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wb_stall,
  output logic                      mem_stall,
  input  logic                      st_flush,
  input  logic                      du_flush,
  input  logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           mem_pc,
  input  logic [ILEN-1:0]           ex_instr,
  output logic [ILEN-1:0]           mem_instr,
  input  logic                      ex_bubble,
  output logic                      mem_bubble,
  input  logic [EXCEPTION_SIZE-1:0] ex_exception,
  output logic [EXCEPTION_SIZE-1:0] mem_exception,
  input  logic [XLEN-1:0]           ex_r,
  output logic [XLEN-1:0]           mem_r,
  input  logic [XLEN-1:0]           dmem_adr,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      dmem_misaligned,
  input  logic                      dmem_page_fault
);

  mem_state_t                state, state_nxt;
  logic                      flush, ex_load, adv, ld_ack;
  logic                      bubble_r, fault;
  logic [1:0]                adr_r;
  logic [XLEN-1:0]           r_r, hold_r, fmt_q, ld_r;
  logic [EXCEPTION_SIZE-1:0] exc_r, fault_exc;

  assign flush   = st_flush | du_flush;
  // A flushed instruction enters as a bubble, so it can never start a load.
  assign ex_load = (ex_instr[6:0] == OPC_LOAD) && !ex_bubble && !flush;
  assign adv     = !mem_stall && !wb_stall;
  assign ld_ack  = (state == WAIT) && dmem_ack;

`ifdef RISCV_MEM_ACCESS_FAULT_EN
  assign fault = dmem_misaligned | dmem_page_fault;
  always_comb begin
    fault_exc = '0;
    fault_exc[CAUSE_MISALIGNED_LOAD] = dmem_misaligned;
    fault_exc[CAUSE_LOAD_PAGE_FAULT] = dmem_page_fault;
  end
`else
  logic unused_fault;
  assign fault        = 1'b0;
  assign fault_exc    = '0;
  assign unused_fault = dmem_misaligned ^ dmem_page_fault;
`endif

  logic unused_adr;
  assign unused_adr = ^dmem_adr[XLEN-1:2];

  riscv_mem_ldfmt #(.XLEN(XLEN)) u_ldfmt (
    .funct3 (mem_instr[14:12]),
    .adr    (adr_r),
    .q      (dmem_q),
    .r      (fmt_q)
  );

  assign ld_r = fault ? '0 : fmt_q;

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: if (!wb_stall && ex_load) state_nxt = WAIT;
      WAIT: begin
        mem_stall = !dmem_ack;
        if (flush)         state_nxt = dmem_ack ? IDLE : DRAIN;
        else if (dmem_ack) state_nxt = wb_stall ? HOLD : (ex_load ? WAIT : IDLE);
      end
      HOLD: begin
        if (flush)          state_nxt = IDLE;
        else if (!wb_stall) state_nxt = ex_load ? WAIT : IDLE;
      end
      DRAIN: begin
        mem_stall = 1'b1;
        if (dmem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_r = r_r;
    case (state)
      WAIT:    mem_r = dmem_ack ? ld_r : r_r;
      HOLD:    mem_r = hold_r;
      default: mem_r = r_r;
    endcase
  end

  assign mem_exception = exc_r | (ld_ack ? fault_exc : '0);
  assign mem_bubble    = bubble_r | (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      mem_pc    <= PC_INIT;
      mem_instr <= INSTR_NOP;
      bubble_r  <= 1'b1;
      exc_r     <= '0;
      r_r       <= '0;
      adr_r     <= '0;
      hold_r    <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        mem_instr <= INSTR_NOP;
        bubble_r  <= 1'b1;
        exc_r     <= '0;
      end else if (adv) begin
        mem_instr <= ex_instr;
        bubble_r  <= ex_bubble;
        exc_r     <= ex_exception;
      end else if (ld_ack) begin
        // Going to HOLD: keep any fault causes alongside the held data.
        exc_r <= exc_r | fault_exc;
      end
      if (adv) begin
        mem_pc <= ex_pc;
        r_r    <= ex_r;
        adr_r  <= dmem_adr[1:0];
      end
      if (ld_ack && wb_stall && !flush) hold_r <= ld_r;
    end
  end

endmodule

// File: tb/tb_riscv_mem.sv
// tb/tb_riscv_mem.sv - directed self-checking bench for riscv_mem
module tb_riscv_mem;
  import riscv_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] I_ADD = 32'h0000_00B3;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      wb_stall = 1'b0;
  logic                      mem_stall;
  logic                      st_flush = 1'b0, du_flush = 1'b0;
  logic [XLEN-1:0]           ex_pc, mem_pc;
  logic [ILEN-1:0]           ex_instr, mem_instr;
  logic                      ex_bubble, mem_bubble;
  logic [EXCEPTION_SIZE-1:0] ex_exception, mem_exception;
  logic [XLEN-1:0]           ex_r, mem_r;
  logic [XLEN-1:0]           dmem_adr;
  logic                      dmem_ack = 1'b0;
  logic [XLEN-1:0]           dmem_q = '0;
  logic                      dmem_misaligned = 1'b0, dmem_page_fault = 1'b0;

  int checks = 0;
  int errors = 0;

  riscv_mem #(.XLEN(XLEN), .PC_INIT('h200)) dut (
    .clk(clk), .rstn(rstn), .wb_stall(wb_stall), .mem_stall(mem_stall),
    .st_flush(st_flush), .du_flush(du_flush),
    .ex_pc(ex_pc), .mem_pc(mem_pc), .ex_instr(ex_instr), .mem_instr(mem_instr),
    .ex_bubble(ex_bubble), .mem_bubble(mem_bubble),
    .ex_exception(ex_exception), .mem_exception(mem_exception),
    .ex_r(ex_r), .mem_r(mem_r), .dmem_adr(dmem_adr), .dmem_ack(dmem_ack),
    .dmem_q(dmem_q), .dmem_misaligned(dmem_misaligned), .dmem_page_fault(dmem_page_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ld_instr(input logic [2:0] f3);
    return {17'd0, f3, 5'd1, 7'b000_0011};
  endfunction

  task automatic ex_idle();
    ex_instr = INSTR_NOP; ex_bubble = 1'b1; ex_r = '0; ex_pc = 32'h0;
    ex_exception = '0; dmem_adr = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] r,
                       input logic [1:0] adr, input logic [EXCEPTION_SIZE-1:0] exc);
    ex_instr = instr; ex_bubble = 1'b0; ex_r = r; dmem_adr = {30'd0, adr};
    ex_pc = 32'h1000; ex_exception = exc;
    tick();
    ex_idle();
  endtask

  task automatic test_reset();
    rstn = 1'b0; ex_idle();
    tick(); tick();
    @(negedge clk);
    checks++; if (mem_pc !== 32'h200) begin errors++; $display("FAIL reset_pc got %h exp %h", mem_pc, 32'h200); end
    checks++; if (mem_instr !== INSTR_NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", mem_instr, INSTR_NOP); end
    checks++; if (mem_bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble got %b exp 1", mem_bubble); end
    checks++; if (mem_exception !== '0) begin errors++; $display("FAIL reset_exc got %h exp 0", mem_exception); end
    checks++; if (mem_r !== 32'h0) begin errors++; $display("FAIL reset_r got %h exp 0", mem_r); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", mem_stall); end
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_add();
    issue(I_ADD, 32'h1234, 2'd0, 16'h0004);
    @(negedge clk);
    checks++; if (mem_r !== 32'h1234) begin errors++; $display("FAIL add_r got %h exp %h", mem_r, 32'h1234); end
    checks++; if (mem_bubble !== 1'b0) begin errors++; $display("FAIL add_bubble got %b exp 0", mem_bubble); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL add_stall got %b exp 0", mem_stall); end
    checks++; if (mem_pc !== 32'h1000) begin errors++; $display("FAIL add_pc got %h exp %h", mem_pc, 32'h1000); end
    checks++; if (mem_instr !== I_ADD) begin errors++; $display("FAIL add_instr got %h exp %h", mem_instr, I_ADD); end
    checks++; if (mem_exception !== 16'h0004) begin errors++; $display("FAIL add_exc got %h exp 0004", mem_exception); end
  endtask

  task automatic test_flush_nonload();
    ex_instr = I_ADD; ex_bubble = 1'b0; ex_r = 32'h55; ex_exception = 16'h0100; du_flush = 1'b1;
    tick();
    du_flush = 1'b0; ex_idle();
    @(negedge clk);
    checks++; if (mem_bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble got %b exp 1", mem_bubble); end
    checks++; if (mem_instr !== INSTR_NOP) begin errors++; $display("FAIL flush_instr got %h exp %h", mem_instr, INSTR_NOP); end
    checks++; if (mem_exception !== '0) begin errors++; $display("FAIL flush_exc got %h exp 0", mem_exception); end
  endtask

  task automatic test_back_to_back();
    issue(ld_instr(F3_LB), 32'h0, 2'd2, '0);
    dmem_ack = 1'b1; dmem_q = 32'h0080_0000;
    ex_instr = ld_instr(F3_LBU); ex_bubble = 1'b0; dmem_adr = 32'd2;
    @(negedge clk);
    checks++; if (mem_r !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_r got %h exp %h", mem_r, 32'hFFFF_FF80); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lb_stall got %b exp 0", mem_stall); end
    tick();
    ex_idle();
    @(negedge clk);
    checks++; if (mem_r !== 32'h0000_0080) begin errors++; $display("FAIL lbu_r got %h exp %h", mem_r, 32'h0000_0080); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lbu_stall got %b exp 0", mem_stall); end
    checks++; if (mem_bubble !== 1'b0) begin errors++; $display("FAIL lbu_bubble got %b exp 0", mem_bubble); end
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_stall got %b exp 0", mem_stall); end
    checks++; if (mem_bubble !== 1'b1) begin errors++; $display("FAIL b2b_idle_bubble got %b exp 1", mem_bubble); end
  endtask

  task automatic test_lw_late();
    issue(ld_instr(F3_LW), 32'h0, 2'd0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw_wait_stall[%0d] got %b exp 1", i, mem_stall); end
      tick();
    end
    dmem_ack = 1'b1; dmem_q = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_ack_stall got %b exp 0", mem_stall); end
    checks++; if (mem_r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_r got %h exp %h", mem_r, 32'hDEAD_BEEF); end
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_after_stall got %b exp 0", mem_stall); end
  endtask

  task automatic test_hold();
    issue(ld_instr(F3_LH), 32'h0, 2'd2, '0);
    dmem_ack = 1'b1; dmem_q = 32'h8001_0000; wb_stall = 1'b1;
    @(negedge clk);
    checks++; if (mem_r !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_ack_r got %h exp %h", mem_r, 32'hFFFF_8001); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lh_ack_stall got %b exp 0", mem_stall); end
    tick();
    dmem_ack = 1'b0; dmem_q = 32'h0;
    @(negedge clk);
    checks++; if (mem_r !== 32'hFFFF_8001) begin errors++; $display("FAIL hold1_r got %h exp %h", mem_r, 32'hFFFF_8001); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hold1_stall got %b exp 0", mem_stall); end
    tick();
    wb_stall = 1'b0;
    @(negedge clk);
    checks++; if (mem_r !== 32'hFFFF_8001) begin errors++; $display("FAIL hold2_r got %h exp %h", mem_r, 32'hFFFF_8001); end
    tick();
    @(negedge clk);
    checks++; if (mem_r !== 32'h0) begin errors++; $display("FAIL hold_exit_r got %h exp 0", mem_r); end
    checks++; if (mem_bubble !== 1'b1) begin errors++; $display("FAIL hold_exit_bubble got %b exp 1", mem_bubble); end
  endtask

  task automatic test_drain();
    issue(ld_instr(F3_LW), 32'h0, 2'd0, '0);
    st_flush = 1'b1;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL drain_flush_stall got %b exp 1", mem_stall); end
    tick();
    st_flush = 1'b0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL drain_stall got %b exp 1", mem_stall); end
    checks++; if (mem_bubble !== 1'b1) begin errors++; $display("FAIL drain_bubble got %b exp 1", mem_bubble); end
    tick();
    dmem_ack = 1'b1; dmem_q = 32'h1234_5678;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL drain_ack_stall got %b exp 1", mem_stall); end
    checks++; if (mem_bubble !== 1'b1) begin errors++; $display("FAIL drain_ack_bubble got %b exp 1", mem_bubble); end
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL drain_exit_stall got %b exp 0", mem_stall); end
    checks++; if (mem_r !== 32'h0) begin errors++; $display("FAIL drain_exit_r got %h exp 0", mem_r); end
    checks++; if (mem_instr !== INSTR_NOP) begin errors++; $display("FAIL drain_exit_instr got %h exp %h", mem_instr, INSTR_NOP); end
  endtask

  task automatic test_fault();
    issue(ld_instr(F3_LW), 32'h0, 2'd0, '0);
    dmem_ack = 1'b1; dmem_misaligned = 1'b1; dmem_q = 32'hFFFF_FFFF;
    @(negedge clk);
`ifdef RISCV_MEM_ACCESS_FAULT_EN
    checks++; if (mem_exception[CAUSE_MISALIGNED_LOAD] !== 1'b1) begin errors++; $display("FAIL misal_exc got %h exp bit4 set", mem_exception); end
    checks++; if (mem_r !== 32'h0) begin errors++; $display("FAIL misal_r got %h exp 0", mem_r); end
`else
    checks++; if (mem_exception[CAUSE_MISALIGNED_LOAD] !== 1'b0) begin errors++; $display("FAIL misal_exc got %h exp bit4 clear", mem_exception); end
    checks++; if (mem_r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL misal_r got %h exp %h", mem_r, 32'hFFFF_FFFF); end
`endif
    tick();
    dmem_ack = 1'b0; dmem_misaligned = 1'b0;
    issue(ld_instr(F3_LW), 32'h0, 2'd0, '0);
    dmem_ack = 1'b1; dmem_page_fault = 1'b1; wb_stall = 1'b1;
    tick();
    dmem_ack = 1'b0; dmem_page_fault = 1'b0;
    @(negedge clk);
`ifdef RISCV_MEM_ACCESS_FAULT_EN
    checks++; if (mem_exception[CAUSE_LOAD_PAGE_FAULT] !== 1'b1) begin errors++; $display("FAIL pf_hold_exc got %h exp bit13 set", mem_exception); end
    checks++; if (mem_r !== 32'h0) begin errors++; $display("FAIL pf_hold_r got %h exp 0", mem_r); end
`else
    checks++; if (mem_exception[CAUSE_LOAD_PAGE_FAULT] !== 1'b0) begin errors++; $display("FAIL pf_hold_exc got %h exp bit13 clear", mem_exception); end
    checks++; if (mem_r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pf_hold_r got %h exp %h", mem_r, 32'hFFFF_FFFF); end
`endif
    wb_stall = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    issue(ld_instr(F3_LW), 32'h0, 2'd0, '0);
    @(negedge clk);
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rst_wait_stall got %b exp 1", mem_stall); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_after_stall got %b exp 0", mem_stall); end
    checks++; if (mem_pc !== 32'h200) begin errors++; $display("FAIL rst_after_pc got %h exp %h", mem_pc, 32'h200); end
    checks++; if (mem_bubble !== 1'b1) begin errors++; $display("FAIL rst_after_bubble got %b exp 1", mem_bubble); end
  endtask

  initial begin
    ex_idle();
    test_reset();
    test_add();
    test_flush_nonload();
    test_back_to_back();
    test_lw_late();
    test_hold();
    test_drain();
    test_fault();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
